// File: rtl/modexp_pkg.sv
// modexp_pkg: shared definitions for the modular-exponentiation job scheduler.
//   state_e          scheduler FSM states (IDLE, LOAD, RUN, RESP)
//   ENG_ITER_CYCLES  cycles the shared engine spends per square-and-multiply iteration
//   WD_CNT_W         width of the RUN-state watchdog counter (MODEXP_WATCHDOG_EN builds)
package modexp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned ENG_ITER_CYCLES = 22;
  localparam int unsigned WD_CNT_W        = 12;

endpackage

// File: rtl/modexp_arbiter_rr.sv
// rr_arbiter: round-robin grant selection.
//   req_i  in   NUM_REQ  request vector
//   ptr_i  in   PTR_W    index where the search starts (wraps to 0)
//   gnt_o  out  NUM_REQ  one-hot grant, zero when nothing requests
//   any_o  out  1        a grant was issued
module rr_arbiter
  import modexp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    gnt_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: shares one modular-exponentiation engine between NUM_REQ
// requesters. Jobs are accepted round-robin over valid/ready, the operands are
// held on the engine ports, the engine is started with a one-cycle eng_start,
// and the result is returned to the owning requester over valid/ready.
//   clk, reset                          clock, synchronous active-high reset
//   req_valid/req_ready                 per-requester job handshake
//   req_base/req_exponent/req_modulo    flattened operands, slice i = requester i
//   rsp_valid/rsp_ready                 per-requester result handshake
//   rsp_result, rsp_err                 shared result bus, error flag (modulo 0 / timeout)
//   busy                                high whenever not IDLE
//   eng_base/eng_exponent/eng_modulo    engine operands
//   eng_start, eng_finish, eng_result   engine load pulse, done strobe, result
// Optional: define MODEXP_WATCHDOG_EN to abort a RUN after TIMEOUT_CYCLES cycles.
module modexp_arbiter
  import modexp_pkg::*;
#(
  parameter int unsigned WORDSIZE       = 16,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*2*WORDSIZE-1:0]  req_base,
  input  logic [NUM_REQ*2*WORDSIZE-1:0]  req_exponent,
  input  logic [NUM_REQ*2*WORDSIZE-1:0]  req_modulo,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [2*WORDSIZE-1:0]          rsp_result,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [2*WORDSIZE-1:0]          eng_base,
  output logic [2*WORDSIZE-1:0]          eng_exponent,
  output logic [2*WORDSIZE-1:0]          eng_modulo,
  output logic                           eng_start,
  input  logic                           eng_finish,
  input  logic [2*WORDSIZE-1:0]          eng_result
);

  localparam int unsigned OPW   = 2 * WORDSIZE;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // A watchdog shorter than one engine iteration could never let a job finish.
  if (TIMEOUT_CYCLES < ENG_ITER_CYCLES || TIMEOUT_CYCLES >= (1 << WD_CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in [ENG_ITER_CYCLES, 2**WD_CNT_W)");
  end

  state_e               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [OPW-1:0]       rsp_result_q;
  logic                 rsp_err_q;
  logic                 busy_q;
  logic [OPW-1:0]       eng_base_q;
  logic [OPW-1:0]       eng_exponent_q;
  logic [OPW-1:0]       eng_modulo_q;
  logic                 eng_start_q;
`ifdef MODEXP_WATCHDOG_EN
  logic [WD_CNT_W-1:0]  wd_q;
`endif

  logic [NUM_REQ-1:0]   gnt;
  logic                 any_gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [OPW-1:0]       sel_base;
  logic [OPW-1:0]       sel_exponent;
  logic [OPW-1:0]       sel_modulo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .any_o (any_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign ptr_next     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign owner_oh     = NUM_REQ'(1) << owner_q;
  assign sel_base     = req_base[gnt_idx*OPW +: OPW];
  assign sel_exponent = req_exponent[gnt_idx*OPW +: OPW];
  assign sel_modulo   = req_modulo[gnt_idx*OPW +: OPW];

  // Ready is the only combinational output; masked during reset so every
  // output reads zero while reset is held.
  assign req_ready    = (state_q == ST_IDLE && !reset) ? gnt : '0;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign eng_base     = eng_base_q;
  assign eng_exponent = eng_exponent_q;
  assign eng_modulo   = eng_modulo_q;
  assign eng_start    = eng_start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      eng_base_q     <= '0;
      eng_exponent_q <= '0;
      eng_modulo_q   <= '0;
      eng_start_q    <= 1'b0;
`ifdef MODEXP_WATCHDOG_EN
      wd_q           <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_gnt) begin
            owner_q        <= gnt_idx;
            ptr_q          <= ptr_next;
            eng_base_q     <= sel_base;
            eng_exponent_q <= sel_exponent;
            eng_modulo_q   <= sel_modulo;
            // Start is registered here so it is high during LOAD; a zero
            // modulo never touches the engine.
            eng_start_q    <= (sel_modulo != '0);
            busy_q         <= 1'b1;
            state_q        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          eng_start_q <= 1'b0;
          if (eng_modulo_q == '0) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= owner_oh;
            state_q      <= ST_RESP;
          end else begin
`ifdef MODEXP_WATCHDOG_EN
            wd_q         <= '0;
`endif
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (eng_finish) begin
            rsp_result_q <= eng_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= owner_oh;
            state_q      <= ST_RESP;
          end
`ifdef MODEXP_WATCHDOG_EN
          else if (wd_q == WD_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= owner_oh;
            state_q      <= ST_RESP;
          end else begin
            wd_q <= wd_q + WD_CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (|(rsp_ready & rsp_valid_q)) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
module tb_modexp_arbiter;
  import modexp_pkg::*;

  localparam int unsigned WS  = 16;
  localparam int unsigned NR  = 2;
  localparam int unsigned OPW = 2 * WS;
  localparam int unsigned TMO = 50;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*OPW-1:0] req_base, req_exponent, req_modulo;
  logic [OPW-1:0]    rsp_result, eng_base, eng_exponent, eng_modulo, eng_result;
  logic              rsp_err, busy, eng_start, eng_finish;

  modexp_arbiter #(.WORDSIZE(WS), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_exponent(req_exponent), .req_modulo(req_modulo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .eng_base(eng_base), .eng_exponent(eng_exponent), .eng_modulo(eng_modulo),
    .eng_start(eng_start), .eng_finish(eng_finish), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned owner;
    logic [31:0] result;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned starts = 0;
  int unsigned grants = 0;
  int unsigned acc_cyc [NR];

  logic [2*NR+OPW+2+3*OPW:0] all_outs;
  assign all_outs = {req_ready, rsp_valid, rsp_result, rsp_err, busy,
                     eng_base, eng_exponent, eng_modulo, eng_start};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_start) starts <= starts + 1;

  // Engine stub: finish strobes 22*(bitlen(exp)+1) cycles after the start cycle.
  function automatic int unsigned bitlen(input logic [31:0] e);
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [31:0] mexp(input logic [31:0] b, e, m);
    logic [63:0] r, x;
    if (m == 0) return 0;
    r = 64'(1) % 64'(m);
    x = 64'(b) % 64'(m);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[31:0];
  endfunction

  int unsigned eng_cnt = 0;
  logic [31:0] eng_res = '0;
  bit          eng_hang = 1'b0;
  always @(posedge clk) begin
    if (eng_start) begin
      eng_cnt <= eng_hang ? 0 : ENG_ITER_CYCLES * (bitlen(eng_exponent) + 1);
      eng_res <= mexp(eng_base, eng_exponent, eng_modulo);
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign eng_finish = (eng_cnt == 1);
  assign eng_result = eng_res;

  // One clock: record handshakes at the falling edge, drop handshaken valid/ready after the rising edge.
  task automatic step();
    logic [NR-1:0] hs, rh;
    @(negedge clk);
    hs = req_valid & req_ready;
    rh = rsp_valid & rsp_ready;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        acc_cyc[i] = cyc;
        grants++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
    rsp_ready = rsp_ready & ~rh;
  endtask

  task automatic set_req(input int i, input logic [31:0] b, e, m);
    req_base[i*OPW +: OPW]     = b;
    req_exponent[i*OPW +: OPW] = e;
    req_modulo[i*OPW +: OPW]   = m;
    req_valid[i]               = 1'b1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (|rsp_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic consume();
    rsp_ready = rsp_valid;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_base = '0; req_exponent = '0; req_modulo = '0;
    repeat (3) step();
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    exp_t e; bit ok;
    set_req(0, 4, 13, 497);
    sb.push_back('{0, 32'd445, 1'b0, 2 + 22 * 5});
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", busy); end
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL single_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== (2'(1) << e.owner)) begin failures++; $display("FAIL single_owner got=%b want=%b", rsp_valid, 2'(1) << e.owner); end
      checks++;
      if ({rsp_err, rsp_result} !== {e.err, e.result}) begin failures++; $display("FAIL single_result got=%b/%0d want=%b/%0d", rsp_err, rsp_result, e.err, e.result); end
      checks++;
      if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL single_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
      consume();
      checks++;
      if ({busy, rsp_valid} !== 3'b000) begin failures++; $display("FAIL single_release got=%b want=000", {busy, rsp_valid}); end
    end
  endtask

  task automatic test_exp_zero();
    exp_t e; bit ok;
    set_req(1, 5, 0, 97);
    sb.push_back('{1, 32'd1, 1'b0, 2 + 22});
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL expzero_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== (2'(1) << e.owner)) begin failures++; $display("FAIL expzero_owner got=%b want=%b", rsp_valid, 2'(1) << e.owner); end
      checks++;
      if ({rsp_err, rsp_result} !== {e.err, e.result}) begin failures++; $display("FAIL expzero_result got=%b/%0d want=%b/%0d", rsp_err, rsp_result, e.err, e.result); end
      checks++;
      if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL expzero_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
      consume();
    end
  endtask

  // Both requesters raise valid together; 'first' is where the pointer sits.
  task automatic test_simultaneous(input int first);
    exp_t e; bit ok;
    exp_t j0, j1;
    j0 = '{0, 32'd24, 1'b0, 2 + 22 * 5};
    j1 = '{1, 32'd5, 1'b0, 2 + 22 * 4};
    set_req(0, 2, 10, 1000);
    set_req(1, 3, 5, 7);
    if (first == 0) begin sb.push_back(j0); sb.push_back(j1); end
    else begin sb.push_back(j1); sb.push_back(j0); end
    step();
    checks++;
    if ({req_valid, req_ready} !== {2'(1) << (1 - first), 2'b00}) begin
      failures++; $display("FAIL simul_pending got=%b want=%b", {req_valid, req_ready}, {2'(1) << (1 - first), 2'b00});
    end
    for (int k = 0; k < 2; k++) begin
      wait_rsp(ok);
      if (!ok) begin checks++; failures++; $display("FAIL simul_timeout got=no_rsp want=rsp"); end
      else begin
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== (2'(1) << e.owner)) begin failures++; $display("FAIL simul_owner got=%b want=%b", rsp_valid, 2'(1) << e.owner); end
        checks++;
        if ({rsp_err, rsp_result} !== {e.err, e.result}) begin failures++; $display("FAIL simul_result got=%b/%0d want=%b/%0d", rsp_err, rsp_result, e.err, e.result); end
        checks++;
        if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL simul_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
        consume();
      end
    end
  endtask

  task automatic test_mod_zero();
    exp_t e; bit ok;
    int unsigned s0;
    s0 = starts;
    set_req(0, 5, 3, 0);
    sb.push_back('{0, 32'd0, 1'b1, 2});
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL modzero_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== (2'(1) << e.owner)) begin failures++; $display("FAIL modzero_owner got=%b want=%b", rsp_valid, 2'(1) << e.owner); end
      checks++;
      if ({rsp_err, rsp_result} !== {e.err, e.result}) begin failures++; $display("FAIL modzero_result got=%b/%0d want=%b/%0d", rsp_err, rsp_result, e.err, e.result); end
      checks++;
      if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL modzero_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
      checks++;
      if (starts !== s0) begin failures++; $display("FAIL modzero_no_start got=%0d want=%0d", starts - s0, 0); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    int unsigned g0;
    set_req(1, 7, 3, 11);
    sb.push_back('{1, 32'd2, 1'b0, 2 + 22 * 3});
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL bp_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      set_req(0, 2, 3, 5);
      sb.push_back('{0, 32'd3, 1'b0, 2 + 22 * 3});
      g0 = grants;
      for (int k = 0; k < 10; k++) begin
        checks++;
        if ({rsp_valid, rsp_err, rsp_result} !== {2'(1) << e.owner, e.err, e.result}) begin
          failures++; $display("FAIL bp_hold got=%b/%b/%0d want=%b/%b/%0d", rsp_valid, rsp_err, rsp_result, 2'(1) << e.owner, e.err, e.result);
        end
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_no_ready got=%b want=00", req_ready); end
        step();
      end
      checks++;
      if (grants !== g0) begin failures++; $display("FAIL bp_no_grant got=%0d want=%0d", grants, g0); end
      consume();
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_regrant got=%b want=01", req_ready); end
      wait_rsp(ok);
      if (!ok) begin checks++; failures++; $display("FAIL bp2_timeout got=no_rsp want=rsp"); end
      else begin
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_err, rsp_result} !== {2'(1) << e.owner, e.err, e.result}) begin
          failures++; $display("FAIL bp2_result got=%b/%b/%0d want=%b/%b/%0d", rsp_valid, rsp_err, rsp_result, 2'(1) << e.owner, e.err, e.result);
        end
        checks++;
        if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL bp2_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
        consume();
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e; bit ok;
    bit stray;
    set_req(0, 4, 13, 497);
    repeat (20) step();
    reset = 1'b1;
    step();
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL midreset_outputs got=%h want=0", all_outs); end
    reset = 1'b0;
    stray = 1'b0;
    for (int n = 0; n < 300 && eng_cnt != 0; n++) begin
      step();
      if (busy || (|rsp_valid)) stray = 1'b1;
    end
    checks++;
    if ({stray, eng_cnt != 0} !== 2'b00) begin failures++; $display("FAIL midreset_stale_finish got=%b want=00", {stray, eng_cnt != 0}); end
    set_req(1, 3, 5, 7);
    sb.push_back('{1, 32'd5, 1'b0, 2 + 22 * 4});
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL midreset_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_err, rsp_result} !== {2'(1) << e.owner, e.err, e.result}) begin
        failures++; $display("FAIL midreset_result got=%b/%b/%0d want=%b/%b/%0d", rsp_valid, rsp_err, rsp_result, 2'(1) << e.owner, e.err, e.result);
      end
      checks++;
      if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL midreset_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
      consume();
    end
  endtask

`ifdef MODEXP_WATCHDOG_EN
  task automatic test_watchdog();
    exp_t e; bit ok;
    eng_hang = 1'b1;
    set_req(0, 3, 5, 7);
    sb.push_back('{0, 32'd0, 1'b1, 2 + TMO});
    wait_rsp(ok);
    if (!ok) begin checks++; failures++; $display("FAIL wd_timeout got=no_rsp want=rsp"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_err, rsp_result} !== {2'(1) << e.owner, e.err, e.result}) begin
        failures++; $display("FAIL wd_result got=%b/%b/%0d want=%b/%b/%0d", rsp_valid, rsp_err, rsp_result, 2'(1) << e.owner, e.err, e.result);
      end
      checks++;
      if (cyc - acc_cyc[e.owner] !== e.lat) begin failures++; $display("FAIL wd_latency got=%0d want=%0d", cyc - acc_cyc[e.owner], e.lat); end
      consume();
    end
    eng_hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();          // pointer -> 1
    test_exp_zero();        // pointer -> 0
    test_simultaneous(0);   // pointer -> 0
    test_mod_zero();        // pointer -> 1
    test_simultaneous(1);   // pointer -> 1
    test_backpressure();
    test_reset_mid_run();
`ifdef MODEXP_WATCHDOG_EN
    test_watchdog();
`endif
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
